// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M execute unit beside the integer ALU.
// It runs an iterative shift-add multiplier or a restoring divider on operand
// magnitudes and fixes up the sign when the last step is done. BUSY holds the
// pipeline while an op is accepted or calculating.
// Ports:
//   CLK          rising-edge clock
//   RESET        synchronous, active-low reset
//   START        valid M-op in ID/EX this cycle
//   FUNC3        M-extension funct3 (MUL..REMU)
//   OP1, OP2     forwarded rs1/rs2 values
//   FLUSH        kill the in-flight op
//   MEM_BUSYWAIT downstream stall; a finished result is held
//   BUSY         stall request to the hazard unit
//   RESULT       registered result
//   RESULT_VALID RESULT is final and may be captured
`timescale 1ns/1ps
module ex_muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OP1,
    input  logic [XLEN-1:0] OP2,
    input  logic            FLUSH,
    input  logic            MEM_BUSYWAIT,
    output logic            BUSY,
    output logic [XLEN-1:0] RESULT,
    output logic            RESULT_VALID
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] hi, lo, opb;
    logic [2:0]      func;
    logic            neg_q, neg_r;
    logic [CW-1:0]   count;

    // Operand decode at acceptance
    logic            op1_signed, op2_signed, op1_neg, op2_neg;
    logic [XLEN-1:0] op1_mag, op2_mag;
    logic            div_zero, overflow, special, accept, last;
    logic [XLEN-1:0] special_result;

    always_comb begin
        op1_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b010) ||
                     (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
        op2_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
        op1_neg    = op1_signed && OP1[XLEN-1];
        op2_neg    = op2_signed && OP2[XLEN-1];
        op1_mag    = op1_neg ? -OP1 : OP1;
        op2_mag    = op2_neg ? -OP2 : OP2;
        div_zero   = FUNC3[2] && (OP2 == '0);
        overflow   = FUNC3[2] && !FUNC3[0] && (OP2 == '1) &&
                     (OP1 == {1'b1, {(XLEN-1){1'b0}}});
        special    = div_zero || overflow;
        if (div_zero)
            special_result = FUNC3[1] ? OP1 : '1;
        else
            special_result = FUNC3[1] ? '0 : OP1;
        accept = (state == IDLE) && START && !FLUSH;
        last   = (count + CW'(BITS_PER_CYCLE)) == CW'(XLEN);
    end

    // Iteration datapath: {hi,lo} is the product accumulator for multiply,
    // or {remainder, dividend/quotient} for the restoring divider.
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [XLEN:0]     sum, shifted;
    logic              ge;
    logic [2*XLEN-1:0] signed_prod;
    logic [XLEN-1:0]   quo, rem, fixed_result;

    always_comb begin
        step_hi = hi;
        step_lo = lo;
        sum     = '0;
        shifted = '0;
        ge      = 1'b0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (func[2]) begin
                shifted = {step_hi, step_lo[XLEN-1]};
                ge      = shifted >= {1'b0, opb};
                step_hi = ge ? (shifted[XLEN-1:0] - opb) : shifted[XLEN-1:0];
                step_lo = {step_lo[XLEN-2:0], ge};
            end else begin
                sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opb} : '0);
                step_lo = {sum[0], step_lo[XLEN-1:1]};
                step_hi = sum[XLEN:1];
            end
        end
        signed_prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo         = neg_q ? -step_lo : step_lo;
        rem         = neg_r ? -step_hi : step_hi;
        if (func[2])
            fixed_result = func[1] ? rem : quo;
        else if (func[1:0] == 2'b00)
            fixed_result = signed_prod[XLEN-1:0];
        else
            fixed_result = signed_prod[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (FLUSH)     state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE: if (FLUSH || !MEM_BUSYWAIT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        BUSY         = accept || (state == CALC);
        RESULT_VALID = (state == DONE);
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            func   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            count  <= '0;
            RESULT <= '0;
        end else if (accept) begin
            hi    <= '0;
            lo    <= op1_mag;
            opb   <= op2_mag;
            func  <= FUNC3;
            neg_q <= op1_neg ^ op2_neg;
            neg_r <= op1_neg;
            count <= '0;
            if (special)
                RESULT <= special_result;
        end else if (state == CALC && !FLUSH) begin
            hi    <= step_hi;
            lo    <= step_lo;
            count <= count + CW'(BITS_PER_CYCLE);
            if (last)
                RESULT <= fixed_result;
        end else if (FLUSH) begin
            count <= '0;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, mem_busywait;
    logic [2:0]  func3;
    logic [31:0] op1, op2;
    logic        busy, valid, busy4, valid4;
    logic [31:0] result, result4;

    int cmp   = 0;
    int fails = 0;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                           F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                           F_REM = 3'b110, F_REMU = 3'b111;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .CLK(clk), .RESET(rst_n), .START(start), .FUNC3(func3), .OP1(op1), .OP2(op2),
        .FLUSH(flush), .MEM_BUSYWAIT(mem_busywait), .BUSY(busy), .RESULT(result),
        .RESULT_VALID(valid)
    );

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .CLK(clk), .RESET(rst_n), .START(start), .FUNC3(func3), .OP1(op1), .OP2(op2),
        .FLUSH(flush), .MEM_BUSYWAIT(mem_busywait), .BUSY(busy4), .RESULT(result4),
        .RESULT_VALID(valid4)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts an op in the current cycle (cycle 0), waits for RESULT_VALID with a
    // bound, reports latency/result and whether BUSY was 1 before DONE and 0 at
    // DONE, then steps into the following cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output bit busy_ok);
        start = 1'b1; func3 = f; op1 = a; op2 = b;
        #1;
        busy_ok = (busy === 1'b1);
        tick();
        start = 1'b0;
        lat = 1;
        while (valid !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        res = result;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; mem_busywait = 1'b0;
        func3 = '0; op1 = '0; op2 = '0;
        tick(); tick();
        cmp++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        cmp++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
        cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; bit bok;
        run_op(F_MUL, 32'd7, 32'hFFFFFFFD, lat, res, bok);
        cmp++; if (lat !== 33) begin fails++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        cmp++; if (res !== 32'hFFFFFFEB) begin fails++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        cmp++; if (bok !== 1'b1) begin fails++; $display("FAIL mul_busy got=%b exp=1", bok); end
    endtask

    task automatic test_mulh();
        int lat; logic [31:0] res; bit bok;
        run_op(F_MULH, 32'h80000000, 32'h80000000, lat, res, bok);
        cmp++; if (res !== 32'h40000000) begin fails++; $display("FAIL mulh got=%h exp=40000000", res); end
        run_op(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, bok);
        cmp++; if (res !== 32'hFFFFFFFE) begin fails++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
        run_op(F_MULHSU, 32'hFFFFFFFF, 32'd2, lat, res, bok);
        cmp++; if (res !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
        cmp++; if (lat !== 33) begin fails++; $display("FAIL mulhsu_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_div();
        int lat; logic [31:0] res; bit bok;
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat, res, bok);
        cmp++; if (res !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg got=%h exp=fffffffd", res); end
        run_op(F_REM, 32'hFFFFFFF9, 32'd2, lat, res, bok);
        cmp++; if (res !== 32'hFFFFFFFF) begin fails++; $display("FAIL rem_neg got=%h exp=ffffffff", res); end
        run_op(F_DIVU, 32'd100, 32'd7, lat, res, bok);
        cmp++; if (res !== 32'd14) begin fails++; $display("FAIL divu got=%h exp=%h", res, 32'd14); end
        cmp++; if (lat !== 33) begin fails++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        run_op(F_REMU, 32'd100, 32'd7, lat, res, bok);
        cmp++; if (res !== 32'd2) begin fails++; $display("FAIL remu got=%h exp=%h", res, 32'd2); end
    endtask

    task automatic test_special();
        int lat; logic [31:0] res; bit bok;
        run_op(F_DIV, 32'd5, 32'd0, lat, res, bok);
        cmp++; if (res !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_by_zero got=%h exp=ffffffff", res); end
        cmp++; if (lat !== 1) begin fails++; $display("FAIL div_by_zero_latency got=%0d exp=1", lat); end
        run_op(F_REMU, 32'd5, 32'd0, lat, res, bok);
        cmp++; if (res !== 32'd5) begin fails++; $display("FAIL remu_by_zero got=%h exp=%h", res, 32'd5); end
        cmp++; if (lat !== 1) begin fails++; $display("FAIL remu_by_zero_latency got=%0d exp=1", lat); end
        run_op(F_DIVU, 32'd9, 32'd0, lat, res, bok);
        cmp++; if (res !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu_by_zero got=%h exp=ffffffff", res); end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, res, bok);
        cmp++; if (res !== 32'h80000000) begin fails++; $display("FAIL div_overflow got=%h exp=80000000", res); end
        cmp++; if (lat !== 1) begin fails++; $display("FAIL div_overflow_latency got=%0d exp=1", lat); end
        run_op(F_REM, 32'h80000000, 32'hFFFFFFFF, lat, res, bok);
        cmp++; if (res !== 32'h0) begin fails++; $display("FAIL rem_overflow got=%h exp=0", res); end
    endtask

    task automatic test_flush();
        int lat; int seen; logic [31:0] res; bit bok;
        run_op(F_MUL, 32'd2, 32'd3, lat, res, bok);
        cmp++; if (res !== 32'd6) begin fails++; $display("FAIL flush_pre got=%h exp=%h", res, 32'd6); end
        // cycle 0: start an op, flush it in cycle 10
        start = 1'b1; func3 = F_MUL; op1 = 32'd7; op2 = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // cycle 11
        cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got=%b exp=0", busy); end
        cmp++; if (valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%b exp=0", valid); end
        cmp++; if (result !== 32'd6) begin fails++; $display("FAIL flush_result_kept got=%h exp=%h", result, 32'd6); end
        tick();
        // cycle 12: new op completes in cycle 45
        run_op(F_DIVU, 32'd9, 32'd3, lat, res, bok);
        cmp++; if (res !== 32'd3) begin fails++; $display("FAIL after_flush_divu got=%h exp=%h", res, 32'd3); end
        cmp++; if (12 + lat !== 45) begin fails++; $display("FAIL after_flush_cycle got=%0d exp=45", 12 + lat); end
        // FLUSH together with START in IDLE: op not accepted
        start = 1'b1; flush = 1'b1; func3 = F_MUL; op1 = 32'd4; op2 = 32'd4;
        #1;
        cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
        tick();
        start = 1'b0; flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1 || valid === 1'b1) seen++;
            tick();
        end
        cmp++; if (seen !== 0) begin fails++; $display("FAIL flush_start_accepted got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen;
        start = 1'b1; func3 = F_MUL; op1 = 32'd7; op2 = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmp++; if (result !== 32'h0) begin fails++; $display("FAIL midreset_result got=%h exp=0", result); end
        cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        cmp++; if (seen !== 0) begin fails++; $display("FAIL midreset_idle got=%0d exp=0", seen); end
    endtask

    task automatic test_busywait();
        int lat; int stable;
        start = 1'b1; func3 = F_DIVU; op1 = 32'd100; op2 = 32'd7;
        tick();
        start = 1'b0;
        lat = 1;
        while (valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        cmp++; if (lat !== 33) begin fails++; $display("FAIL busywait_latency got=%0d exp=33", lat); end
        mem_busywait = 1'b1;
        stable = (valid === 1'b1 && result === 32'd14) ? 1 : 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) mem_busywait = 1'b0;
            if (k == 1) begin
                // START during DONE is ignored and does not stall
                start = 1'b1; func3 = F_MUL; op1 = 32'd9; op2 = 32'd9;
                #1;
                cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL done_start_busy got=%b exp=0", busy); end
                start = 1'b0;
            end
            if (valid === 1'b1 && result === 32'd14) stable++;
        end
        cmp++; if (stable !== 4) begin fails++; $display("FAIL busywait_stable got=%0d exp=4", stable); end
        tick();
        cmp++; if (valid !== 1'b0) begin fails++; $display("FAIL busywait_release got=%b exp=0", valid); end
        cmp++; if (result !== 32'd14) begin fails++; $display("FAIL busywait_result_kept got=%h exp=%h", result, 32'd14); end
        cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL busywait_idle_busy got=%b exp=0", busy); end
        for (int i = 0; i < 40; i++) tick();
    endtask

    task automatic test_radix4();
        int lat; int lat1;
        start = 1'b1; func3 = F_MUL; op1 = 32'd3; op2 = 32'd5;
        #1;
        cmp++; if (busy4 !== 1'b1) begin fails++; $display("FAIL radix4_busy got=%b exp=1", busy4); end
        tick();
        start = 1'b0;
        lat = 1;
        while (valid4 !== 1'b1 && lat < 100) begin tick(); lat++; end
        cmp++; if (lat !== 9) begin fails++; $display("FAIL radix4_latency got=%0d exp=9", lat); end
        cmp++; if (result4 !== 32'd15) begin fails++; $display("FAIL radix4_result got=%h exp=%h", result4, 32'd15); end
        lat1 = lat;
        while (valid !== 1'b1 && lat1 < 100) begin tick(); lat1++; end
        cmp++; if (result !== 32'd15) begin fails++; $display("FAIL radix1_same_op got=%h exp=%h", result, 32'd15); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_busywait();
        test_radix4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
